// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end sharing one single-cycle alu between two requesters.
// Latency: accept cycle -> one EXEC cycle -> response valid; at least 3 cycles per operation.
// Backpressure: one operation in flight; both request readies stay low until the owner's response handshakes.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_y,
  output logic             resp0_zero,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_y,
  output logic             resp1_zero,
  // shared alu
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_zero,
  // completed-response counter
  output logic [15:0]      op_count
);

  // alu_ctrl encoding shared with the alu (constant_values.h)
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_OFF = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
  } oper_t;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             zero;
  } result_t;

  state_t      state;
  state_t      state_nxt;
  logic        owner;
  logic        last_grant;
  oper_t       oper_q;
  result_t     result_q;
  logic [15:0] op_count_q;
  logic        grant0;
  logic        grant1;
  logic        resp_hs;
  logic        op_legal;

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign op_count   = op_count_q;
  assign resp_hs    = (state == RESP) && (owner ? resp1_ready : resp0_ready);

  // Decode whether the latched op is one of the five codes the alu implements
  always_comb begin
    case (oper_q.op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: op_legal = 1'b1;
      default:                                   op_legal = 1'b0;
    endcase
  end

  // Round-robin grant in IDLE: a lone requester wins, a tie goes to the one not granted last
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && (!req1_valid || last_grant)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: accept -> one EXEC cycle -> hold RESP until the owner takes it
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant0 || grant1) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Drive the alu only during EXEC; an illegal op keeps it switched off
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = ALU_OFF;
    if (state == EXEC) begin
      alu_a = oper_q.a;
      alu_b = oper_q.b;
      if (op_legal) begin
        alu_ctrl = oper_q.op;
      end
    end
  end

  // Route the result register to the owner's response channel; the other channel reads zero
  always_comb begin
    resp0_valid = 1'b0;
    resp0_y     = '0;
    resp0_zero  = 1'b0;
    resp1_valid = 1'b0;
    resp1_y     = '0;
    resp1_zero  = 1'b0;
    if (state == RESP) begin
      if (!owner) begin
        resp0_valid = 1'b1;
        resp0_y     = result_q.y;
        resp0_zero  = result_q.zero;
      end else begin
        resp1_valid = 1'b1;
        resp1_y     = result_q.y;
        resp1_zero  = result_q.zero;
      end
    end
  end

  // Capture operands on accept and the alu result at the end of EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      oper_q     <= '0;
      result_q   <= '0;
      op_count_q <= '0;
    end else begin
      if (grant0 || grant1) begin
        owner      <= grant1;
        last_grant <= grant1;
        oper_q.a   <= grant1 ? req1_a  : req0_a;
        oper_q.b   <= grant1 ? req1_b  : req0_b;
        oper_q.op  <= grant1 ? req1_op : req0_op;
      end
      if (state == EXEC) begin
        result_q.y    <= op_legal ? alu_y : '0;
        result_q.zero <= op_legal ? alu_zero : 1'b1;
        op_count_q    <= op_count_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural alu attached.
// Stimulus pushes expected responses per requester; a negedge monitor pops and compares.
// Directed vectors cover reset, arbitration order, SLT, backpressure, illegal ops and mid-op reset.
module tb_alu_arbiter;
  localparam int W = 32;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_OFF = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_zero;
  logic          req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_zero;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b, resp0_y, resp1_y;
  logic [2:0]    req0_op, req1_op, alu_ctrl;
  logic [W-1:0]  alu_a, alu_b, alu_y, m_y;
  logic          alu_zero;
  logic [15:0]   op_count;

  typedef struct packed {
    logic [W-1:0] y;
    logic         zero;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_y(resp0_y), .resp0_zero(resp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_y(resp1_y), .resp1_zero(resp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_y(alu_y), .alu_zero(alu_zero),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural alu; unknown codes return a poison value so an unmasked illegal op shows up
  always_comb begin
    case (alu_ctrl)
      OP_AND:  m_y = alu_a & alu_b;
      OP_OR:   m_y = alu_a | alu_b;
      OP_ADD:  m_y = alu_a + alu_b;
      OP_SUB:  m_y = alu_a - alu_b;
      OP_SLT:  m_y = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: m_y = 32'hDEAD_BEEF;
    endcase
  end
  assign alu_y    = m_y;
  assign alu_zero = (m_y == '0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop the scoreboard on each response handshake and check channel invariants
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp0_valid && resp0_ready) begin
        if (q0.size() == 0) begin
          check("resp0_unexpected", 32'(resp0_valid), 32'd0);
        end else begin
          e0 = q0.pop_front();
          check("resp0_y", resp0_y, e0.y);
          check("resp0_zero", 32'(resp0_zero), 32'(e0.zero));
        end
      end
      if (resp1_valid && resp1_ready) begin
        if (q1.size() == 0) begin
          check("resp1_unexpected", 32'(resp1_valid), 32'd0);
        end else begin
          e1 = q1.pop_front();
          check("resp1_y", resp1_y, e1.y);
          check("resp1_zero", 32'(resp1_zero), 32'(e1.zero));
        end
      end
      check("one_resp_valid", 32'(resp0_valid & resp1_valid), 32'd0);
      check("one_req_ready", 32'(req0_ready & req1_ready), 32'd0);
      if (!resp0_valid) check("resp0_idle_out", {31'd0, resp0_zero} | resp0_y, 32'd0);
      if (!resp1_valid) check("resp1_idle_out", {31'd0, resp1_zero} | resp1_y, 32'd0);
    end
  end

  // Present one request, wait (bounded) for ready, then drop valid after the handshake edge
  task automatic issue(input int port, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] op, input bit push, input logic [W-1:0] ey,
                       input logic ez, output int acc);
    exp_t e;
    bit   got;
    e.y    = ey;
    e.zero = ez;
    if (push) begin
      if (port == 0) q0.push_back(e);
      else           q1.push_back(e);
    end
    acc = -1;
    got = 1'b0;
    @(posedge clk); #1;
    if (port == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if ((port == 0) ? req0_ready : req1_ready) begin
        got = 1'b1;
        acc = cyc;
      end
    end
    check($sformatf("accept_p%0d", port), 32'(got), 32'd1);
    @(posedge clk); #1;
    if (port == 0) req0_valid = 1'b0;
    else           req1_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected response has been seen, then move to the next IDLE
  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(q0.size() + q1.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #3;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int  ta, tb2, tc, td, tdummy, lat;
    bit  seen, bad;
    exp_t e;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = OP_AND;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = OP_AND;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    #2;
    // Reset state
    check("rst_resp0_valid", 32'(resp0_valid), 32'd0);
    check("rst_resp1_valid", 32'(resp1_valid), 32'd0);
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_req1_ready", 32'(req1_ready), 32'd0);
    check("rst_alu_ctrl", 32'(alu_ctrl), 32'(OP_OFF));
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    req0_valid = 1'b1;
    #1;
    check("rst_ready_follows_valid", 32'(req0_ready), 32'd1);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // SUB with latency and alu drive checks
    issue(0, 32'd8, 32'd41, OP_SUB, 1'b1, 32'hFFFF_FFDF, 1'b0, ta);
    @(negedge clk);
    check("sub_exec_ctrl", 32'(alu_ctrl), 32'(OP_SUB));
    check("sub_exec_a", alu_a, 32'd8);
    check("sub_exec_b", alu_b, 32'd41);
    seen = 1'b0;
    lat  = -1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (resp0_valid) begin
        seen = 1'b1;
        lat  = cyc - ta;
        check("sub_resp_ctrl_off", 32'(alu_ctrl), 32'(OP_OFF));
      end
    end
    check("sub_latency", lat, 32'd2);
    drain();
    check("sub_op_count", 32'(op_count), 32'd1);

    // Ties from reset with both requesters re-requesting: grants alternate
    do_reset();
    fork
      begin
        issue(0, 32'd41, 32'd8, OP_ADD, 1'b1, 32'd49, 1'b0, ta);
        issue(0, 32'd41, 32'd8, OP_OR,  1'b1, 32'd41, 1'b0, tc);
      end
      begin
        issue(1, 32'd41, 32'd8, OP_AND, 1'b1, 32'd8, 1'b0, tb2);
        issue(1, 32'd8,  32'd8, OP_SUB, 1'b1, 32'd0, 1'b1, td);
      end
    join
    drain();
    check("tie_req0_first", 32'(ta < tb2), 32'd1);
    check("tie_req1_second", 32'(tb2 < tc), 32'd1);
    check("tie_req0_third", 32'(tc < td), 32'd1);
    check("tie_op_count", 32'(op_count), 32'd4);

    // Signed SLT
    issue(1, 32'hFFFF_FFFD, 32'hFFFF_FFFB, OP_SLT, 1'b1, 32'd0, 1'b1, tdummy);
    issue(1, 32'hFFFF_FFFB, 32'hFFFF_FFFD, OP_SLT, 1'b1, 32'd1, 1'b0, tdummy);
    issue(1, 32'd41,        32'hFFFF_FFFF, OP_SLT, 1'b1, 32'd0, 1'b1, tdummy);
    drain();
    check("slt_op_count", 32'(op_count), 32'd7);

    // Response backpressure holds the result and blocks the other requester
    resp0_ready = 1'b0;
    issue(0, 32'd5, 32'd7, OP_ADD, 1'b1, 32'd12, 1'b0, ta);
    req1_valid = 1'b1; req1_a = 32'hFF; req1_b = 32'h0F; req1_op = OP_AND;
    e.y = 32'h0F;
    e.zero = 1'b0;
    q1.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (resp0_valid) seen = 1'b1;
      else check("bp_req1_blocked_exec", 32'(req1_ready), 32'd0);
    end
    check("bp_resp_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_hold_valid", 32'(resp0_valid), 32'd1);
      check("bp_hold_y", resp0_y, 32'd12);
      check("bp_hold_zero", 32'(resp0_zero), 32'd0);
      check("bp_req1_blocked", 32'(req1_ready), 32'd0);
    end
    @(posedge clk); #1;
    resp0_ready = 1'b1;
    @(negedge clk);
    check("bp_req1_blocked_hs", 32'(req1_ready), 32'd0);
    @(negedge clk);
    check("bp_req1_ready_after", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    drain();
    check("bp_op_count", 32'(op_count), 32'd9);

    // Illegal ops: alu stays off, result is y=0/zero=1, count still advances
    bad = 1'b0;
    fork
      issue(0, 32'd123, 32'd456, OP_OFF, 1'b1, 32'd0, 1'b1, tdummy);
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (alu_ctrl !== OP_OFF) bad = 1'b1;
      end
    join
    check("illegal_off_ctrl", 32'(bad), 32'd0);
    drain();
    check("illegal_off_count", 32'(op_count), 32'd10);
    bad = 1'b0;
    fork
      issue(1, 32'd9, 32'd9, 3'b100, 1'b1, 32'd0, 1'b1, tdummy);
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (alu_ctrl !== OP_OFF) bad = 1'b1;
      end
    join
    check("illegal_100_ctrl", 32'(bad), 32'd0);
    drain();
    check("illegal_100_count", 32'(op_count), 32'd11);

    // Reset during EXEC drops the transaction without a clock edge
    issue(0, 32'd1, 32'd1, OP_ADD, 1'b0, 32'd0, 1'b0, tdummy);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_alu_ctrl", 32'(alu_ctrl), 32'(OP_OFF));
    check("midrst_alu_a", alu_a, 32'd0);
    check("midrst_resp0_valid", 32'(resp0_valid), 32'd0);
    check("midrst_op_count", 32'(op_count), 32'd0);
    check("midrst_req1_ready", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_no_resp", 32'(resp0_valid | resp1_valid), 32'd0);
    issue(0, 32'd1, 32'd2, OP_ADD, 1'b1, 32'd3, 1'b0, tdummy);
    drain();
    check("midrst_after_count", 32'(op_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
